mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 25 ++
 rtl/mem_lsu_if.sv | 20 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/mem_lsu.sv | 121 ++++++++++++
 tb/tb_mem_lsu.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings and FSM states.
// Pure declarations, no timing.
// No flow control lives here.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Illegal size or an offset that does not suit the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_X) ||
           ((size == SZ_H) && off[0]) ||
           ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Requester-side bus of the load/store unit.
// Combinational wiring only.
// Single outstanding access: req is only accepted while busy is low.
interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;

  modport master (output req, we, size, uns, addr, wdata,
                  input  rdata, done, err, busy);
  modport slave  (input  req, we, size, uns, addr, wdata,
                  output rdata, done, err, busy);
endinterface

// File: rtl/lsu_align.sv
// Big-endian byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational, zero cycles.
// No backpressure; outputs follow inputs.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld,
  output logic [31:0] o_st
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  // Pick the addressed byte/half (offset 0 is the most significant lane) and extend it.
  always_comb begin
    w_b = 8'h00;
    case (i_off)
      2'd0:    w_b = i_rword[31:24];
      2'd1:    w_b = i_rword[23:16];
      2'd2:    w_b = i_rword[15:8];
      default: w_b = i_rword[7:0];
    endcase
    w_h = i_off[1] ? i_rword[15:0] : i_rword[31:16];
    case (i_size)
      SZ_B:    o_ld = i_uns ? {24'h0, w_b} : {{24{w_b[7]}}, w_b};
      SZ_H:    o_ld = i_uns ? {16'h0, w_h} : {{16{w_h[15]}}, w_h};
      default: o_ld = i_rword;
    endcase
  end

  // Overlay the store data onto the word read back, leaving the other lanes intact.
  always_comb begin
    o_st = i_rword;
    case (i_size)
      SZ_B: begin
        case (i_off)
          2'd0:    o_st[31:24] = i_wdata[7:0];
          2'd1:    o_st[23:16] = i_wdata[7:0];
          2'd2:    o_st[15:8]  = i_wdata[7:0];
          default: o_st[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (i_off[1]) o_st[15:0]  = i_wdata[15:0];
        else          o_st[31:16] = i_wdata[15:0];
      end
      default: o_st = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one access at a time against a word-wide memory, sub-word stores by read-modify-write.
// done 1 cycle after acceptance for errors, 2 for loads/word stores, 3 for sub-word stores.
// req is ignored while busy; there is no queueing.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  mem_lsu_if.slave    bus,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  state_e      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_wr;

  logic        w_bad;
  logic [31:0] w_ld;
  logic [31:0] w_st;

  assign w_bad = misaligned(bus.size, bus.addr[1:0]) || (bus.addr >= 32'(MEM_BYTES));

  lsu_align u_align (
    .i_size  (r_size),
    .i_uns   (r_uns),
    .i_off   (r_off),
    .i_rword (mem_rdata),
    .i_wdata (r_wdata),
    .o_ld    (w_ld),
    .o_st    (w_st)
  );

  // Access sequencer; every output is a flop so the memory sees clean signals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_size      <= SZ_B;
      r_uns       <= 1'b0;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_wr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_uns   <= bus.uns;
            r_off   <= bus.addr[1:0];
            r_wdata <= bus.wdata;
            if (w_bad) begin
              r_state <= RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_mem_addr <= {bus.addr[31:2], 2'b00};
              if (bus.we && (bus.size == SZ_W)) begin
                r_state     <= WR;
                r_mem_wdata <= bus.wdata;
                r_mem_wr    <= 1'b1;
              end else begin
                // Loads and sub-word stores both need the current word first.
                r_state <= RD;
              end
            end
          end
        end
        RD: begin
          if (r_we) begin
            r_state     <= WR;
            r_mem_wdata <= w_st;
            r_mem_wr    <= 1'b1;
          end else begin
            r_state <= RESP;
            r_rdata <= w_ld;
            r_done  <= 1'b1;
          end
        end
        WR: begin
          r_state  <= RESP;
          r_mem_wr <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.busy  = (r_state != IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised bench for mem_lsu against a byte-array reference model.
// Memory model captures on the falling edge, as the attached RAM does.
// One access at a time; busy-time req pokes must be ignored.
module tb_mem_lsu;

  localparam int MEMB = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  mem_lsu_if bus ();

  mem_lsu #(.MEM_BYTES(MEMB)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide RAM seen by the DUT.
  logic [31:0] ram [0:MEMB/4-1];
  always @(negedge clk) begin
    if (mem_wr) ram[mem_addr[9:2]] <= mem_wdata;
    else        mem_rdata <= ram[mem_addr[9:2]];
  end

  // Reference model: plain byte array, big-endian.
  logic [7:0]  ref_mem [0:MEMB-1];
  logic [31:0] ref_rdata;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    int align;
    align = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return (sz == 2'd3) || (a >= MEMB) || ((a % align) != 0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    logic [31:0] v;
    int i;
    i = int'(a);
    if (sz == 2'd0) begin
      v = 32'(ref_mem[i]);
      if (!u && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = 32'(ref_mem[i]) * 256 + 32'(ref_mem[i+1]);
      if (!u && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = model_word(a);
    end
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i;
    int nb;
    logic [31:0] d;
    i  = int'(a);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    d  = wd;
    for (int k = nb - 1; k >= 0; k--) begin
      ref_mem[i + k] = d[7:0];
      d = d >> 8;
    end
  endtask

  task automatic count_stray_done(input string tag);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  // One access through the DUT, checked against the model. poke holds req high
  // with different request fields while the access is in flight.
  task automatic do_acc(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input bit poke);
    bit   e;
    int   lat_exp;
    int   lat;
    int   wr_cnt;
    logic err_seen;
    e       = model_err(sz, a);
    lat_exp = e ? 1 : ((!w || sz == 2'd2) ? 2 : 3);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    if (poke) begin
      bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h0; bus.wdata = $urandom;
    end else begin
      bus.req = 1'b0;
    end
    lat = 0; wr_cnt = 0; err_seen = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n == 1) check("busy_after_accept", bus.busy, 1);
      if (mem_wr) wr_cnt++;
      if (bus.done) begin
        lat = n;
        err_seen = bus.err;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    check("latency", lat, lat_exp);
    check("err", err_seen, e);
    check("mem_wr_cycles", wr_cnt, (w && !e) ? 1 : 0);
    if (!e) begin
      if (w) model_store(sz, a, wd);
      else   ref_rdata = model_load(sz, u, a);
    end
    check("rdata", bus.rdata, ref_rdata);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    if (w && !e) check("mem_word", ram[a[9:2]], model_word(a));
    if (poke) count_stray_done("poke_done_count");
  endtask

  initial begin
    logic [31:0] wv;
    n_checks = 0; n_fail = 0; ref_rdata = 32'h0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.uns = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < MEMB / 4; i++) begin
      wv = $urandom;
      ram[i] = wv;
      ref_mem[4*i] = wv[31:24]; ref_mem[4*i+1] = wv[23:16];
      ref_mem[4*i+2] = wv[15:8]; ref_mem[4*i+3] = wv[7:0];
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus.rdata, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Word store then load back.
    do_acc(1, 2'd2, 0, 32'h10, 32'h12345678, 0);
    do_acc(0, 2'd2, 0, 32'h10, 32'h0, 0);
    check("lw10", bus.rdata, 32'h12345678);

    // Sign/zero extension on a known word.
    do_acc(1, 2'd2, 0, 32'h20, 32'h80FF7F01, 0);
    do_acc(0, 2'd0, 0, 32'h20, 32'h0, 0);
    check("lb20", bus.rdata, 32'hFFFFFF80);
    do_acc(0, 2'd0, 1, 32'h20, 32'h0, 0);
    check("lbu20", bus.rdata, 32'h00000080);
    do_acc(0, 2'd1, 0, 32'h20, 32'h0, 0);
    check("lh20", bus.rdata, 32'hFFFF80FF);
    do_acc(0, 2'd1, 1, 32'h22, 32'h0, 0);
    check("lhu22", bus.rdata, 32'h00007F01);

    // Read-modify-write stores.
    do_acc(1, 2'd0, 0, 32'h21, 32'hFFFFFFAB, 0);
    check("sb21", ram[8], 32'h80AB7F01);
    do_acc(1, 2'd1, 0, 32'h22, 32'h55551234, 0);
    check("sh22", ram[8], 32'h80AB1234);

    // Rejected accesses leave rdata alone.
    do_acc(0, 2'd2, 0, 32'h22, 32'h0, 0);
    do_acc(0, 2'd1, 0, 32'h23, 32'h0, 0);
    do_acc(0, 2'd3, 0, 32'h20, 32'h0, 0);
    do_acc(0, 2'd2, 0, 32'h400, 32'h0, 0);
    do_acc(1, 2'd0, 0, 32'h400, 32'h0, 0);
    check("rdata_after_errs", bus.rdata, 32'h00007F01);

    // Reset in the middle of a sub-word store's write cycle.
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.uns = 1'b0;
    bus.addr = 32'h21; bus.wdata = 32'hCD;
    @(posedge clk); #1; bus.req = 1'b0;
    @(posedge clk); #1;
    check("wr_phase_mem_wr", mem_wr, 1);
    rst = 1'b0; #1;
    check("arst_mem_wr", mem_wr, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_rdata", bus.rdata, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    ref_rdata = 32'h0;
    @(negedge clk); rst = 1'b1;
    count_stray_done("arst_no_done");
    check("arst_mem_kept", ram[8], model_word(32'h20));
    do_acc(0, 2'd2, 0, 32'h20, 32'h0, 0);
    check("after_arst_lw", bus.rdata, 32'h80AB1234);

    // req held/changed while busy is ignored.
    do_acc(0, 2'd2, 0, 32'h10, 32'h0, 1);
    do_acc(1, 2'd0, 0, 32'h13, 32'h77, 1);
    do_acc(0, 2'd3, 0, 32'h8, 32'h0, 1);
    do_acc(0, 2'd2, 0, 32'h0, 32'h0, 0);

    // Random mix, concentrated on a small window so data gets reused.
    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(MEMB, MEMB + 80))
                                        : 32'($urandom_range(0, 127));
      do_acc(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
